// File: rtl/pwm_clock_monitor.sv
// Receive-side monitor for a PWM-divided clock: recovers the divider from edge spacing
// and reports lock, loss of clock and mismatch against an expected divider.
module pwm_clock_monitor #(
    parameter int DIV_W      = 5,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             pwm_clk_in,
    input  logic [DIV_W-1:0] expected_divider,
    output logic [DIV_W-1:0] meas_divider,
    output logic             meas_valid,
    output logic             locked,
    output logic             no_clock,
    output logic             divider_err
);
    // state   | meaning
    // SEARCH  | no edge since reset/clear/timeout; interval counter idle at 0
    // MEASURE | timing edge intervals, counting identical measurements
    // LOCKED  | LOCK_COUNT identical measurements seen in a row
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int               CNT_W   = DIV_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] meas_divider_q, meas_divider_d;
    logic [DIV_W-1:0] ref_q, ref_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             no_clock_q, no_clock_d;
    logic             divider_err_q, divider_err_d;

    logic             edge_det;
    logic             in_range;
    logic [DIV_W-1:0] meas_val;
    logic [3:0]       match_inc;

    assign edge_det  = s2_q ^ s3_q;
    assign in_range  = ~cnt_q[CNT_W-1];
    assign meas_val  = cnt_q[DIV_W-1:0];
    assign match_inc = (match_cnt_q >= LOCK_N) ? LOCK_N : match_cnt_q + 4'd1;

    always_comb begin
        s1_d           = pwm_clk_in;
        s2_d           = s1_q;
        s3_d           = s2_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        meas_divider_d = meas_divider_q;
        meas_valid_d   = 1'b0;
        ref_d          = ref_q;
        match_cnt_d    = match_cnt_q;
        divider_err_d  = divider_err_q;

        // Synchronizer keeps running through clear so a pending edge is consumed, not replayed.
        if (clear) begin
            state_d        = SEARCH;
            cnt_d          = '0;
            meas_divider_d = '0;
            ref_d          = '0;
            match_cnt_d    = '0;
            divider_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                SEARCH: begin
                    cnt_d = '0;
                    if (edge_det) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (edge_det) begin
                        cnt_d = '0;
                        if (in_range) begin
                            meas_divider_d = meas_val;
                            meas_valid_d   = 1'b1;
                            if (meas_val == ref_q) begin
                                match_cnt_d = match_inc;
                            end else begin
                                ref_d       = meas_val;
                                match_cnt_d = 4'd1;
                            end
                            state_d = (match_cnt_d == LOCK_N) ? LOCKED : MEASURE;
                            if ((state_d == LOCKED) && (meas_val != expected_divider)) begin
                                divider_err_d = 1'b1;
                            end
                        end else begin
                            match_cnt_d = '0;
                            state_d     = MEASURE;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        // Loss of clock: lock history is dropped so relock takes a full sequence.
                        state_d     = SEARCH;
                        cnt_d       = '0;
                        match_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                end
            endcase
        end

        locked_d   = (state_d == LOCKED);
        no_clock_d = (state_d == SEARCH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= SEARCH;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            cnt_q          <= '0;
            meas_divider_q <= '0;
            meas_valid_q   <= 1'b0;
            ref_q          <= '0;
            match_cnt_q    <= '0;
            locked_q       <= 1'b0;
            no_clock_q     <= 1'b1;
            divider_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            cnt_q          <= cnt_d;
            meas_divider_q <= meas_divider_d;
            meas_valid_q   <= meas_valid_d;
            ref_q          <= ref_d;
            match_cnt_q    <= match_cnt_d;
            locked_q       <= locked_d;
            no_clock_q     <= no_clock_d;
            divider_err_q  <= divider_err_d;
        end
    end

    assign meas_divider = meas_divider_q;
    assign meas_valid   = meas_valid_q;
    assign locked       = locked_q;
    assign no_clock     = no_clock_q;
    assign divider_err  = divider_err_q;

endmodule

// File: tb/tb_pwm_clock_monitor.sv
// Bench for pwm_clock_monitor: an edge-interval reference model feeds a scoreboard that a
// monitor drains on every meas_valid pulse; spot checks cover lock, timeout, reset and clear.
module tb_pwm_clock_monitor;
    localparam int DIV_W = 5;
    localparam int LC    = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear = 1'b0;
    logic             pwm_clk_in = 1'b0;
    logic [DIV_W-1:0] expected_divider = '0;
    logic [DIV_W-1:0] meas_divider;
    logic             meas_valid;
    logic             locked;
    logic             no_clock;
    logic             divider_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int div;
        bit lk;
        bit err;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: works on intervals between input toggles, in clk cycles.
    bit m_search = 1'b1;
    bit m_locked = 1'b0;
    bit m_err    = 1'b0;
    int m_ref    = 0;
    int m_match  = 0;
    int gap      = 0;

    pwm_clock_monitor #(.DIV_W(DIV_W), .LOCK_COUNT(LC)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clear            (clear),
        .pwm_clk_in       (pwm_clk_in),
        .expected_divider (expected_divider),
        .meas_divider     (meas_divider),
        .meas_valid       (meas_valid),
        .locked           (locked),
        .no_clock         (no_clock),
        .divider_err      (divider_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_search = 1'b1;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_ref    = 0;
        m_match  = 0;
        gap      = 0;
    endtask

    task automatic model_edge();
        int g;
        int m;
        g   = gap;
        gap = 0;
        // A silence of 64 cycles after the counter restarts means the clock was lost.
        if (!m_search && g >= 65) begin
            m_search = 1'b1;
            m_locked = 1'b0;
            m_match  = 0;
        end
        if (m_search) begin
            m_search = 1'b0;
            return;
        end
        m = g - 1;
        if (m <= 31) begin
            if (m == m_ref) m_match = (m_match + 1 > LC) ? LC : m_match + 1;
            else begin
                m_ref   = m;
                m_match = 1;
            end
            m_locked = (m_match == LC);
            if (m_locked && m != int'(expected_divider)) m_err = 1'b1;
            sb_q.push_back('{m, m_locked, m_err});
        end else begin
            m_match  = 0;
            m_locked = 1'b0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            gap++;
        end
    endtask

    task automatic toggle_after(input int g);
        while (gap < g) step(1);
        pwm_clk_in = ~pwm_clk_in;
        model_edge();
    endtask

    task automatic run(input int g, input int count);
        repeat (count) toggle_after(g);
    endtask

    task automatic settle(input string name);
        step(5);
        check({name, "_locked"}, locked, int'(m_locked && gap < 67));
        check({name, "_no_clock"}, no_clock, int'(m_search || gap >= 67));
        check({name, "_divider_err"}, divider_err, m_err);
        check({name, "_sb_empty"}, sb_q.size(), 0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (meas_valid) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                check("unexpected_meas_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("meas_divider", meas_divider, e.div);
                check("meas_locked", locked, e.lk);
                check("meas_divider_err", divider_err, e.err);
                check("meas_no_clock", no_clock, 0);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        expected_divider = 5'd3;
        repeat (3) @(negedge clk);
        check("rst_meas_divider", meas_divider, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_no_clock", no_clock, 1);
        check("rst_divider_err", divider_err, 0);
        reset_n = 1'b1;
        model_reset();

        run(4, 8);
        settle("steady_d3");

        run(8, 6);
        settle("change_d7");

        do_clear();
        check("clear_no_clock", no_clock, 1);
        check("clear_divider_err", divider_err, 0);
        expected_divider = 5'd31;
        run(32, 7);
        step(66);
        check("timeout_pre_no_clock", no_clock, 0);
        check("timeout_pre_locked", locked, 1);
        step(1);
        check("timeout_no_clock", no_clock, 1);
        check("timeout_locked", locked, 0);
        run(10, 1);
        settle("after_timeout");

        run(40, 6);
        for (int i = 0; i < 10; i++) toggle_after(int'($urandom_range(33, 64)));
        toggle_after(64);
        settle("out_of_range");

        expected_divider = 5'd3;
        run(4, 6);
        settle("prereset_lock");
        @(negedge clk);
        gap++;
        reset_n    = 1'b0;
        pwm_clk_in = 1'b0;
        #1;
        check("midrst_meas_divider", meas_divider, 0);
        check("midrst_meas_valid", meas_valid, 0);
        check("midrst_locked", locked, 0);
        check("midrst_no_clock", no_clock, 1);
        check("midrst_divider_err", divider_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        run(4, 6);
        settle("post_reset");

        expected_divider = 5'd4;
        run(6, 6);
        settle("preclear_lock");
        while (gap < 6) step(1);
        pwm_clk_in = ~pwm_clk_in;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        check("clredge_meas_divider", meas_divider, 0);
        check("clredge_locked", locked, 0);
        check("clredge_no_clock", no_clock, 1);
        check("clredge_divider_err", divider_err, 0);
        run(6, 6);
        settle("post_clear");

        do_clear();
        expected_divider = 5'd0;
        run(1, 10);
        settle("min_div");

        for (int b = 0; b < 25; b++) begin
            int d;
            int n;
            d = int'($urandom_range(0, 31));
            n = int'($urandom_range(2, 8));
            if ($urandom_range(0, 3) == 0) expected_divider = DIV_W'($urandom_range(0, 31));
            else expected_divider = DIV_W'(d);
            if ($urandom_range(0, 7) == 0) do_clear();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0) toggle_after(int'($urandom_range(33, 64)));
                else toggle_after(d + 1);
            end
            settle("random");
        end

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
